// File: rtl/l0_pkg.sv
// l0_skew_buf shared definitions: read modes, error bit indices and
// the row FIFO pointer-width helper.
package l0_pkg;

    localparam logic L0_MODE_PARALLEL = 1'b0;
    localparam logic L0_MODE_SKEW     = 1'b1;

    localparam int L0_ERR_OVF = 0;
    localparam int L0_ERR_UDF = 1;

    // Address bits plus one wrap bit.
    function automatic int l0_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/l0_row_fifo.sv
// l0_row_fifo: one row of the L0 buffer. Single-clock FIFO with
// wrap-bit pointers, a registered head output and a per-pop valid.
module l0_row_fifo
    import l0_pkg::*;
#(
    parameter int BW    = 4,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [BW-1:0] din_i,
    output logic [BW-1:0] dout_o,
    output logic          valid_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = l0_ptr_w(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [BW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [BW-1:0] dout_q, dout_d;
    logic          valid_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                     (wptr_q[AW] != rptr_q[AW]);

    // Pointer advance and head capture; pops of an empty row are ignored.
    always_comb begin
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        dout_d  = dout_q;
        if (do_push) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_ONE;
            dout_d = mem_q[rptr_q[AW-1:0]];
        end
    end

    // Pointer, output and valid registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            dout_q  <= dout_d;
            valid_q <= do_pop;
        end
    end

    // Storage array; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din_i;
        end
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/l0_skew_buf.sv
// l0_skew_buf: ROW parallel-written row FIFOs read skewed or in parallel.
// Optional sticky error flags (o_err) when L0_ERR_FLAG_EN is defined.
module l0_skew_buf
    import l0_pkg::*;
#(
    parameter int ROW   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr,
    input  logic              rd,
    input  logic              mode,
    input  logic [ROW*BW-1:0] in,
    output logic [ROW*BW-1:0] out,
    output logic [ROW-1:0]    o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_empty
`ifdef L0_ERR_FLAG_EN
    ,
    output logic [1:0]        o_err
`endif
);

    logic [ROW-1:0] rd_en_q, rd_en_d;
    logic [ROW-1:0] empty_v;
    logic [ROW-1:0] full_v;
    logic           wr_acc;

    assign o_full  = |full_v;
    assign o_ready = ~o_full;
    assign o_empty = &empty_v;

    // A write lands in every row or in none.
    assign wr_acc = wr & o_ready;

    // Read tokens travel down the rows; parallel mode also hits all rows.
    always_comb begin
        rd_en_d = {rd_en_q[ROW-2:0], rd};
        if (mode == L0_MODE_PARALLEL) begin
            rd_en_d = rd_en_d | {ROW{rd}};
        end
    end

    // Read-enable shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_en_q <= '0;
        end else begin
            rd_en_q <= rd_en_d;
        end
    end

    for (genvar g = 0; g < ROW; g++) begin : g_row
        l0_row_fifo #(
            .BW    (BW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push_i  (wr_acc),
            .pop_i   (rd_en_q[g]),
            .din_i   (in[g*BW +: BW]),
            .dout_o  (out[g*BW +: BW]),
            .valid_o (o_valid[g]),
            .empty_o (empty_v[g]),
            .full_o  (full_v[g])
        );
    end

`ifdef L0_ERR_FLAG_EN
    logic [1:0] err_q, err_d;

    // Sticky overflow / underflow accumulation.
    always_comb begin
        err_d = err_q;
        if (wr && o_full) begin
            err_d[L0_ERR_OVF] = 1'b1;
        end
        if (|(rd_en_q & empty_v)) begin
            err_d[L0_ERR_UDF] = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`endif

endmodule

// File: tb/tb_l0_skew_buf.sv
// Testbench for l0_skew_buf (ROW=4, BW=4, DEPTH=8): queue-based model
// checked every cycle plus directed literal expectations.
module tb_l0_skew_buf;

    localparam int ROW   = 4;
    localparam int BW    = 4;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              wr = 1'b0;
    logic              rd = 1'b0;
    logic              mode = 1'b0;
    logic [ROW*BW-1:0] din = '0;
    logic [ROW*BW-1:0] dout;
    logic [ROW-1:0]    o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_empty;
`ifdef L0_ERR_FLAG_EN
    logic [1:0]        o_err;
`endif

    int checks = 0;
    int failures = 0;

    l0_skew_buf #(
        .ROW   (ROW),
        .BW    (BW),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr),
        .rd      (rd),
        .mode    (mode),
        .in      (din),
        .out     (dout),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_empty (o_empty)
`ifdef L0_ERR_FLAG_EN
        ,
        .o_err   (o_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [BW-1:0] mq [ROW][$];
    logic [BW-1:0] m_out [ROW];
    logic          m_val [ROW];
    logic          m_tok [ROW];
    logic          m_tok_nx [ROW];
    logic [1:0]    m_err;
    logic          m_anyfull;

    initial begin
        for (int i = 0; i < ROW; i++) begin
            m_out[i] = '0;
            m_val[i] = 1'b0;
            m_tok[i] = 1'b0;
        end
        m_err = 2'b00;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROW; i++) begin
                mq[i].delete();
                m_out[i] = '0;
                m_val[i] = 1'b0;
                m_tok[i] = 1'b0;
            end
            m_err = 2'b00;
        end else begin
            m_anyfull = 1'b0;
            for (int i = 0; i < ROW; i++)
                if (mq[i].size() == DEPTH) m_anyfull = 1'b1;
            if (wr && m_anyfull) m_err[0] = 1'b1;
            for (int i = 0; i < ROW; i++) begin
                m_val[i] = 1'b0;
                if (m_tok[i]) begin
                    if (mq[i].size() > 0) begin
                        m_out[i] = mq[i].pop_front();
                        m_val[i] = 1'b1;
                    end else begin
                        m_err[1] = 1'b1;
                    end
                end
            end
            if (wr && !m_anyfull)
                for (int i = 0; i < ROW; i++)
                    mq[i].push_back(din[i*BW +: BW]);
            for (int i = 0; i < ROW; i++) begin
                m_tok_nx[i] = (i == 0) ? rd : m_tok[i-1];
                if (mode == 1'b0 && rd) m_tok_nx[i] = 1'b1;
            end
            for (int i = 0; i < ROW; i++) m_tok[i] = m_tok_nx[i];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [ROW*BW-1:0] eo;
        logic [ROW-1:0]    ev;
        logic              ef;
        logic              ee;
        ef = 1'b0;
        ee = 1'b1;
        for (int i = 0; i < ROW; i++) begin
            eo[i*BW +: BW] = m_out[i];
            ev[i] = m_val[i];
            if (mq[i].size() == DEPTH) ef = 1'b1;
            if (mq[i].size() != 0) ee = 1'b0;
        end
        chk("m_out", 32'(dout), 32'(eo));
        chk("m_valid", 32'(o_valid), 32'(ev));
        chk("m_full", 32'(o_full), 32'(ef));
        chk("m_ready", 32'(o_ready), 32'(!ef));
        chk("m_empty", 32'(o_empty), 32'(ee));
`ifdef L0_ERR_FLAG_EN
        chk("m_err", 32'(o_err), 32'(m_err));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic w, input logic r, input logic m,
                       input logic [15:0] d);
        wr = w;
        rd = r;
        mode = m;
        din = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        wr = 1'b0;
        rd = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("rst_out", 32'(dout), 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_full", 32'(o_full), 32'h0);
        chk("rst_ready", 32'(o_ready), 32'h1);
        chk("rst_empty", 32'(o_empty), 32'h1);
        reset_n = 1'b1;

        // empty read in skew mode
        cyc(0, 1, 1, 16'h0);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 1, 16'h0);
            chk("udf_valid", 32'(o_valid), 32'h0);
            chk("udf_out", 32'(dout), 32'h0);
        end
`ifdef L0_ERR_FLAG_EN
        chk("udf_err", 32'(o_err), 32'h2);
`endif

        // skew read
        do_reset();
        cyc(1, 0, 1, 16'h3210);
        cyc(1, 0, 1, 16'h7654);
        cyc(0, 1, 1, 16'h0);
        cyc(0, 1, 1, 16'h0);
        chk("sk_v0", 32'(o_valid), 32'h1);
        chk("sk_r0a", 32'(dout[3:0]), 32'h0);
        cyc(0, 0, 1, 16'h0);
        chk("sk_v1", 32'(o_valid), 32'h3);
        chk("sk_r0b", 32'(dout[3:0]), 32'h4);
        chk("sk_r1a", 32'(dout[7:4]), 32'h1);
        cyc(0, 0, 1, 16'h0);
        chk("sk_v2", 32'(o_valid), 32'h6);
        chk("sk_r1b", 32'(dout[7:4]), 32'h5);
        cyc(0, 0, 1, 16'h0);
        chk("sk_v3", 32'(o_valid), 32'hC);
        chk("sk_r3a", 32'(dout[15:12]), 32'h3);
        cyc(0, 0, 1, 16'h0);
        chk("sk_v4", 32'(o_valid), 32'h8);
        chk("sk_r3b", 32'(dout[15:12]), 32'h7);
        chk("sk_all", 32'(dout), 32'h7654);
        cyc(0, 0, 1, 16'h0);
        chk("sk_v5", 32'(o_valid), 32'h0);
        chk("sk_empty", 32'(o_empty), 32'h1);

        // full and dropped write
        for (int k = 1; k <= 8; k++)
            cyc(1, 0, 0, 16'(k * 16'h1111));
        chk("fl_full", 32'(o_full), 32'h1);
        chk("fl_ready", 32'(o_ready), 32'h0);
        cyc(1, 0, 0, 16'h9999);
        chk("fl_full2", 32'(o_full), 32'h1);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 0, 16'h0);
            if (k > 0) chk("fl_rd", 32'(dout), 32'(k * 16'h1111));
        end
        cyc(0, 0, 0, 16'h0);
        chk("fl_rd8", 32'(dout), 32'h8888);
        chk("fl_empty", 32'(o_empty), 32'h1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 16'h0);
        chk("fl_hold", 32'(dout), 32'h8888);

        // parallel read
        cyc(1, 0, 0, 16'hDCBA);
        cyc(0, 1, 0, 16'h0);
        cyc(0, 0, 0, 16'h0);
        chk("par_valid", 32'(o_valid), 32'hF);
        chk("par_out", 32'(dout), 32'hDCBA);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 16'h0);

        // async reset with tokens in flight
        cyc(1, 0, 1, 16'h1234);
        cyc(1, 0, 1, 16'h5678);
        cyc(0, 1, 1, 16'h0);
        cyc(0, 1, 1, 16'h0);
        cyc(0, 1, 1, 16'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_out", 32'(dout), 32'h0);
        chk("ar_valid", 32'(o_valid), 32'h0);
        chk("ar_empty", 32'(o_empty), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 1, 16'h0);
            chk("ar_novalid", 32'(o_valid), 32'h0);
        end

        // simultaneous read and write at full
        do_reset();
        for (int k = 1; k <= 8; k++)
            cyc(1, 0, 1, 16'(k * 16'h1111));
        chk("sw_full", 32'(o_full), 32'h1);
        cyc(1, 1, 1, 16'hAAAA);
        cyc(0, 0, 1, 16'h0);
        chk("sw_valid", 32'(o_valid), 32'h1);
        chk("sw_r0", 32'(dout[3:0]), 32'h1);
        chk("sw_full2", 32'(o_full), 32'h1);
`ifdef L0_ERR_FLAG_EN
        chk("sw_err", 32'(o_err[0]), 32'h1);
`endif
        for (int k = 0; k < 8; k++) cyc(0, 1, 1, 16'h0);
        for (int k = 0; k < 6; k++) cyc(0, 0, 1, 16'h0);
        chk("sw_last", 32'(dout), 32'h8888);
        chk("sw_empty", 32'(o_empty), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l0_skew_buf.md
Name: l0_skew_buf

Overview:
- Parametrised next-generation L0 input buffer: a bank of ROW independent row FIFOs, each BW bits wide and DEPTH entries deep.
- All rows are written together; reads are issued either diagonally staggered (row i reads i cycles after row 0) or in parallel, selected at run time.
- Sits between the activation/weight loader and the MAC array's west edge, feeding skewed operands into a systolic array.
- Adds per-row valid outputs, an all-empty status and a selectable read mode.

Parameters:
- ROW, 8, number of rows/FIFOs; must be at least 2.
- BW, 4, bits per row element.
- DEPTH, 64, entries per row FIFO; must be a power of two and at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- wr  input  1  write request: pushes in[] into all rows.
- rd  input  1  read token: starts a read of row 0, plus rows per mode.
- mode  input  1  0 = PARALLEL, 1 = SKEW.
- in  input  ROW*BW  row i occupies bits [BW*(i+1)-1 : BW*i].
- out  output  ROW*BW  registered read data, same row packing as in.
- o_valid  output  ROW  row i out slice was updated this cycle.
- o_full  output  1  any row FIFO full.
- o_ready  output  1  equals NOT o_full.
- o_empty  output  1  all row FIFOs empty.
- o_err  output  2  present only with L0_ERR_FLAG_EN; bit0 = overflow, bit1 = underflow.

Behaviour:
- Reset (asynchronous, reset_n=0): all row pointers, the read-enable vector rd_en[ROW-1:0], out and o_valid clear to 0; o_full=0, o_ready=1, o_empty=1. Reset asserted mid-stream discards all contents and in-flight read tokens immediately.
- Row FIFO pointers: $clog2(DEPTH)+1 bits each, with a wrap bit. Empty when the pointers are equal; full when the addresses match and the wrap bits differ.
- Write acceptance: a write is accepted iff wr=1 and o_ready=1, evaluated on pre-edge state, and then all ROW rows push. A write while o_full=1 is dropped in full, never partially, even if a read frees space in the same cycle.
- Read-enable update per cycle: SKEW gives rd_en <= {rd_en[ROW-2:0], rd}; PARALLEL gives rd_en <= {rd_en[ROW-2:0], 1'b0} | {ROW{rd}}. Tokens already in flight keep shifting when mode changes, so behaviour stays deterministic.
- Row i read: when rd_en[i]=1 and row i is non-empty, pop the head. out slice i is updated on the next clock edge and o_valid[i]=1 for that cycle.
- Latency: rd to row-0 data is 2 edges. In SKEW, row i data lags row 0 data by i cycles.
- Read of an empty row is ignored: the pointer does not move, the out slice holds its last value, and o_valid[i]=0. There is no write-to-read bypass, so a simultaneous write and read on an empty row returns nothing.
- Simultaneous accepted write and non-empty read on a row: both happen and the occupancy is unchanged.
- Flags: o_full and o_empty are combinational from the pointer state. o_empty is the AND of the per-row empty flags; o_full is the OR of the per-row full flags.

Optional Feature:
- Macro L0_ERR_FLAG_EN.
- Defined: port o_err exists. Bit0 sets sticky on a write dropped because o_full=1. Bit1 sets sticky on any rd_en[i] hitting an empty row. Both bits clear only on reset_n.
- Undefined: o_err port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package l0_pkg holds:
  - L0_MODE_PARALLEL=1'b0 and L0_MODE_SKEW=1'b1;
  - L0_ERR_OVF=0 and L0_ERR_UDF=1 bit indices;
  - a pointer-width helper function.
- Sub-module l0_row_fifo (BW, DEPTH): single-clock FIFO with wrap-bit pointers, registered output, empty/full flags and async active-low reset. It is instantiated ROW times by a generate loop.

Test Plan (ROW=4, BW=4, DEPTH=8):
- Skew read: reset, write 0x3210 then 0x7654, mode=1, pulse rd for 2 cycles starting at T. Required out slices:
  - row0: 0 at T+2 and 4 at T+3;
  - row1: 1 at T+3 and 5 at T+4;
  - row3: 3 at T+5 and 7 at T+6;
  - each o_valid bit is high exactly 2 cycles.
- Full/drop: 8 writes of 0x1111..0x8888 give o_full=1 and o_ready=0. A 9th write of 0x9999 is dropped. Reading out all 8 returns 0x1111..0x8888 in order, and o_empty=1 afterwards.
- Parallel read: write 0xDCBA, mode=0, rd pulse at T. At T+2, o_valid=4'b1111 and out=0xDCBA.
- Empty read: after reset, rd pulse in SKEW mode. o_valid stays 0, out stays 0x0000, and o_err=2'b10 when L0_ERR_FLAG_EN is defined.
- Async reset mid-stream: with 3 tokens in flight, drop reset_n between edges. Required immediately: out=0, o_valid=0, o_empty=1. No o_valid pulses after release.
- Simultaneous read/write at full: fill 8 entries, then assert wr and rd in the same cycle. The write is dropped and row0 pops 1 entry. With the macro defined, o_err bit0=1.
